// File: rtl/ram_sdp_param.sv
// Parametrised simple dual-port RAM: byte-enable writes, write-first bypass, 1/2-cycle read
// latency, post-reset clear sequencer. Optional per-byte parity via `RAM_SDP_PARITY_EN.
module ram_sdp_param #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  wr_drop,
  input  logic                  par_inj,
  output logic                  par_err
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run, do_rd;
  logic [DATA_W-1:0] rd_word;
  logic              rd_mis;
  logic              v1_q, pe1_q, drop_q;
  logic [DATA_W-1:0] d1_q;

  assign run       = (state_q == ST_RUN);
  assign do_rd     = run & rd_en;
  assign init_busy = ~run;
  assign wr_drop   = drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Write-first: bytes being written this edge override the stored word
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < BE_W; i++)
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

`ifdef RAM_SDP_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] wr_par, rd_par;

  always_comb begin
    for (int unsigned i = 0; i < BE_W; i++) wr_par[i] = ^wr_data[8*i +: 8];
    wr_par[0] = wr_par[0] ^ par_inj;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++)
        if (wr_be[i]) par_mem[wr_addr][i] <= wr_par[i];
    end
  end

  always_comb begin
    rd_par = par_mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < BE_W; i++)
        if (wr_be[i]) rd_par[i] = wr_par[i];
    end
    rd_mis = 1'b0;
    for (int unsigned i = 0; i < BE_W; i++)
      if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_mis = 1'b1;
  end
`else
  logic unused_par;
  assign unused_par = par_inj;
  assign rd_mis     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      pe1_q   <= 1'b0;
      d1_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= do_rd;
      pe1_q   <= do_rd & rd_mis;
      drop_q  <= ~run & (wr_en | rd_en);
      if (do_rd) d1_q <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2_q, pe2_q;
      logic [DATA_W-1:0] d2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q  <= 1'b0;
          pe2_q <= 1'b0;
          d2_q  <= '0;
        end else begin
          v2_q  <= v1_q;
          pe2_q <= pe1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end
      assign rd_valid = v2_q;
      assign rd_data  = d2_q;
      assign par_err  = pe2_q;
    end else begin : g_lat1
      assign rd_valid = v1_q;
      assign rd_data  = d1_q;
      assign par_err  = pe1_q;
    end
  endgenerate

endmodule

// File: doc/ram_sdp_param.md
Name: ram_sdp_param

Overview:
Parametrised simple dual-port synchronous RAM. It is the successor to the fixed 64-bit scratch RAM and has one write port and one read port on a single clock. Over the fixed RAM it adds:
- configurable width, depth and read latency
- byte-enable writes
- write-first collision bypass
- a read-valid strobe
- a hardware clear sequencer that zeroes the whole array after every reset

It sits beside the RCA datapath as operand/result storage.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (default 16)
RD_LAT, 1, read latency in cycles; legal values 1 or 2
Derived, not overridable: BE_W = DATA_W/8

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i]
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data, valid when rd_valid=1
rd_valid  out  1  one-cycle strobe marking rd_data valid
init_busy  out  1  high while the clear sequencer runs
wr_drop  out  1  one-cycle pulse: a request arrived during init and was discarded
par_inj  in  1  parity fault inject (used only with PARITY_EN)
par_err  out  1  parity error flag, aligned with rd_valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_data=0, rd_valid=0, wr_drop=0, par_err=0, init_busy=1
  - FSM enters INIT with clear counter=0
  - Array contents are not reset directly; the sequencer clears them.
- FSM states: INIT and RUN.
  - INIT: one word per cycle, mem[cnt] <= 0 (all bytes) and cnt++.
  - When cnt = DEPTH-1 has been written, the next state is RUN and init_busy drops.
  - Total INIT duration is exactly DEPTH cycles after the first clk edge following rst_n rise.
- Reset mid-operation (any state): returns to INIT; in-flight reads are discarded and rd_valid=0.
- During INIT:
  - wr_en and rd_en are ignored; the array is not modified by the user port.
  - If wr_en|rd_en=1, wr_drop=1 on the next cycle; otherwise wr_drop=0.
  - rd_valid stays 0.
- Write (RUN): on a clk edge with wr_en=1, each byte i with wr_be[i]=1 is updated; bytes with wr_be[i]=0 keep their value. wr_be=0 is a legal no-op.
- Read (RUN): rd_en=1 at edge N gives rd_valid=1 and rd_data=word at edge N+RD_LAT.
  - Back-to-back reads are fully pipelined: one result per cycle.
  - When rd_valid=0, rd_data holds its last value.
- RD_LAT=2: adds one output register stage; rd_valid is delayed identically.
- Collision (wr_en & rd_en, same address, same edge): write-first. The returned word is, per byte, the new byte if wr_be[i]=1, else the old byte.
- Read of an address written in the previous cycle returns the new data; no stale window.
- Addresses are always in range (DEPTH = 2**ADDR_W), so there is no wrap handling.

Optional Feature:
- Macro: RAM_SDP_PARITY_EN
- Defined:
  - The array stores one even-parity bit per byte, computed on write over the new byte value. The INIT clear stores parity 0.
  - If par_inj=1 on a write, the stored parity of byte 0 is inverted, provided wr_be[0]=1.
  - On read, parity is recomputed per byte. par_err=1 in the same cycle as rd_valid if any byte mismatches; otherwise par_err=0.
  - A collision bypass uses the freshly computed parity, including any injection.
- Undefined: no parity storage; par_inj is ignored; par_err is tied to 0.

Test Plan:
- Reset then idle, DEPTH=16: init_busy=1 for exactly 16 cycles after rst_n rise. Then read all 16 addresses -> each returns 0 with rd_valid=1 one cycle after rd_en (RD_LAT=1).
- Write 0x0123456789ABCDEF to addr 3 with wr_be=0xFF; then write 0xFFFFFFFFFFFFFFFF with wr_be=0x0F; read addr 3 -> 0x01234567FFFFFFFF.
- Same-cycle write addr 5 of 0xAAAA_AAAA_AAAA_AAAA (be=0xF0) and read addr 5 holding 0x1111_1111_1111_1111 -> rd_data=0xAAAAAAAA11111111.
- RD_LAT=2 build: rd_en on 4 consecutive cycles for addrs 0..3 -> rd_valid high for 4 consecutive cycles starting 2 cycles later, data in order.
- Assert wr_en during INIT with data 0xDEAD -> wr_drop pulses one cycle later. After init, the target address reads 0.
- Assert rst_n=0 mid-read-stream: rd_valid=0 immediately and INIT restarts. With RAM_SDP_PARITY_EN, a write with par_inj=1 followed by a read of that address -> par_err=1 together with rd_valid.
